// File: rtl/gactx_bank3_pkg.sv
// Shared types and sizing helpers for the GACTX bank3 read-burst scheduler.
package gactx_bank3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int LP_DEF_DATA_WIDTH = 512;
  localparam int LP_DEF_BURST_LEN  = 64;
  localparam int LP_BEAT_BYTES     = LP_DEF_DATA_WIDTH / 8;
  localparam int LP_BURST_BYTES    = LP_BEAT_BYTES * LP_DEF_BURST_LEN;

  function automatic int beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

  // One extra bit so the counter can hold the full C_MAX_OUTSTANDING value.
  function automatic int outstanding_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

endpackage

// File: rtl/gactx_bank3_xfer_counter.sv
// Load/increment/decrement counter with a registered zero flag and a look-ahead next value.
module gactx_bank3_xfer_counter
  import gactx_bank3_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         incr,
  input  logic         decr,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         is_zero
);

  logic [W-1:0] count_q, count_d;
  logic         is_zero_q, is_zero_d;

  // Simultaneous incr and decr cancel out.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (incr && !decr) begin
      count_d = count_q + 1'b1;
    end else if (decr && !incr) begin
      count_d = count_q - 1'b1;
    end
    is_zero_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q   <= '0;
      is_zero_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      is_zero_q <= is_zero_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign is_zero    = is_zero_q;

endmodule

// File: rtl/gactx_bank3_rd_burst_sched.sv
// Splits a host read of N beats into AXI AR bursts, throttles in-flight bursts and
// pulses done once every burst has been issued and retired by its R-last.
module gactx_bank3_rd_burst_sched
  import gactx_bank3_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = LP_DEF_DATA_WIDTH,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_BURST_LEN       = LP_DEF_BURST_LEN,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
  output logic                      ctrl_busy,
  output logic                      ctrl_done,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  input  logic                      rlast_hs,
  output logic                      err_underflow
);

  localparam int LP_OUT_W = outstanding_width(C_MAX_OUTSTANDING);
  localparam logic [C_ADDR_WIDTH-1:0]   LP_ADDR_STEP =
    C_ADDR_WIDTH'(C_BURST_LEN * beat_bytes(C_DATA_WIDTH));
  localparam logic [C_LENGTH_WIDTH-1:0] LP_BURST_LEN_LW = C_LENGTH_WIDTH'(C_BURST_LEN);
  localparam logic [8:0]                LP_BURST_LEN_9  = 9'(C_BURST_LEN);
  localparam logic [7:0]                LP_ARLEN_FULL   = 8'(C_BURST_LEN - 1);
  localparam logic [LP_OUT_W-1:0]       LP_MAX_OUT      = LP_OUT_W'(C_MAX_OUTSTANDING);

  sched_state_e              state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      arvalid_q, arvalid_d;
  logic [C_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]                arlen_q, arlen_d;
  logic [8:0]                last_len_q, last_len_d;
  logic                      err_q, err_d;
  logic                      armed_q, armed_d;

  logic                      ar_hs, start_ok, out_dec;
  logic [C_LENGTH_WIDTH-1:0] start_quot, start_rem, start_bursts;
  logic [8:0]                start_last_len;
  logic [C_LENGTH_WIDTH-1:0] burst_count, burst_next;
  logic                      burst_zero;
  logic [LP_OUT_W-1:0]       out_count, out_next;
  logic                      out_zero;

  assign ar_hs    = arvalid_q & m_axi_arready;
  assign start_ok = ctrl_start & ~busy_q;
  // Retirements with nothing in flight are flagged, never counted.
  assign out_dec  = rlast_hs & ~out_zero;

  assign start_quot     = ctrl_length / LP_BURST_LEN_LW;
  assign start_rem      = ctrl_length % LP_BURST_LEN_LW;
  assign start_bursts   = start_quot + C_LENGTH_WIDTH'(start_rem != '0);
  assign start_last_len = (start_rem == '0) ? LP_BURST_LEN_9 : 9'(start_rem);

  gactx_bank3_xfer_counter #(.W(C_LENGTH_WIDTH)) u_bursts_left (
    .clk        (aclk),
    .srst       (areset),
    .load       (start_ok),
    .load_val   (start_bursts),
    .incr       (1'b0),
    .decr       (ar_hs),
    .count      (burst_count),
    .count_next (burst_next),
    .is_zero    (burst_zero)
  );

  gactx_bank3_xfer_counter #(.W(LP_OUT_W)) u_outstanding (
    .clk        (aclk),
    .srst       (areset),
    .load       (start_ok),
    .load_val   ('0),
    .incr       (ar_hs),
    .decr       (out_dec),
    .count      (out_count),
    .count_next (out_next),
    .is_zero    (out_zero)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    last_len_d = last_len_q;
    armed_d    = armed_q;
    err_d      = err_q;

    if (rlast_hs && out_zero && armed_q) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (done_q) begin
          busy_d = 1'b0;
        end
        if (start_ok) begin
          busy_d     = 1'b1;
          armed_d    = 1'b1;
          err_d      = 1'b0;
          araddr_d   = ctrl_addr_offset;
          last_len_d = start_last_len;
          if (start_bursts == '0) begin
            state_d = DONE;
          end else begin
            state_d   = ISSUE;
            arvalid_d = 1'b1;
            arlen_d   = (start_bursts == C_LENGTH_WIDTH'(1)) ? 8'(start_last_len - 9'd1)
                                                               : LP_ARLEN_FULL;
          end
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          if (burst_next == '0) begin
            arvalid_d = 1'b0;
            state_d   = DRAIN;
          end else begin
            // Next request is prepared immediately so AR can issue every cycle.
            araddr_d  = araddr_q + LP_ADDR_STEP;
            arlen_d   = (burst_count == C_LENGTH_WIDTH'(2)) ? 8'(last_len_q - 9'd1)
                                                            : LP_ARLEN_FULL;
            arvalid_d = (out_next < LP_MAX_OUT);
          end
        end else if (!arvalid_q && !burst_zero && ((out_count != LP_MAX_OUT) || out_dec)) begin
          arvalid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (out_next == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      last_len_q <= '0;
      armed_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      last_len_q <= last_len_d;
      armed_q    <= armed_d;
      err_q      <= err_d;
    end
  end

  assign ctrl_busy     = busy_q;
  assign ctrl_done     = done_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_gactx_bank3_rd_burst_sched.sv
// Directed bench for the bank3 read-burst scheduler with hand-computed AR sequences.
module tb_gactx_bank3_rd_burst_sched;
  import gactx_bank3_pkg::*;

  localparam logic [63:0] STEP = 64'(LP_BURST_BYTES);

  logic        aclk = 1'b0;
  logic        areset;
  logic        ctrl_start;
  logic [63:0] ctrl_addr_offset;
  logic [31:0] ctrl_length;
  logic        ctrl_busy;
  logic        ctrl_done;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        rlast_hs;
  logic        err_underflow;

  int checks   = 0;
  int failures = 0;
  int n_ar;

  always #5 aclk = ~aclk;

  gactx_bank3_rd_burst_sched dut (
    .aclk             (aclk),
    .areset           (areset),
    .ctrl_start       (ctrl_start),
    .ctrl_addr_offset (ctrl_addr_offset),
    .ctrl_length      (ctrl_length),
    .ctrl_busy        (ctrl_busy),
    .ctrl_done        (ctrl_done),
    .m_axi_arvalid    (m_axi_arvalid),
    .m_axi_arready    (m_axi_arready),
    .m_axi_araddr     (m_axi_araddr),
    .m_axi_arlen      (m_axi_arlen),
    .rlast_hs         (rlast_hs),
    .err_underflow    (err_underflow)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_ar(input string tag, input logic [63:0] addr, input logic [7:0] len);
    check_val({tag, "_valid"}, 64'(m_axi_arvalid), 64'd1);
    check_val({tag, "_addr"}, m_axi_araddr, addr);
    check_val({tag, "_len"}, 64'(m_axi_arlen), 64'(len));
    $display("AR %s addr=0x%0h len=%0d ready=%0b", tag, m_axi_araddr, m_axi_arlen, m_axi_arready);
  endtask

  task automatic do_start(input logic [63:0] addr, input logic [31:0] len);
    ctrl_start       = 1'b1;
    ctrl_addr_offset = addr;
    ctrl_length      = len;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, 64'(ctrl_busy), 64'd0);
    check_val({tag, "_done"}, 64'(ctrl_done), 64'd0);
    check_val({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    check_val({tag, "_araddr"}, m_axi_araddr, 64'd0);
    check_val({tag, "_arlen"}, 64'(m_axi_arlen), 64'd0);
    check_val({tag, "_err"}, 64'(err_underflow), 64'd0);
  endtask

  initial begin
    areset = 1'b1; ctrl_start = 1'b0; ctrl_addr_offset = '0; ctrl_length = '0;
    m_axi_arready = 1'b0; rlast_hs = 1'b0;
    tick(); tick();
    areset = 1'b0;
    check_idle("reset");

    // len=130 at 0x1000: two full bursts and a 2-beat tail.
    m_axi_arready = 1'b1;
    do_start(64'h1000, 32'd130);
    check_val("t1_busy", 64'(ctrl_busy), 64'd1);
    check_ar("t1_ar0", 64'h1000, 8'd63); tick();
    check_ar("t1_ar1", 64'h2000, 8'd63); tick();
    check_ar("t1_ar2", 64'h3000, 8'd1);  tick();
    check_val("t1_ar_stop", 64'(m_axi_arvalid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick();
      check_val("t1_done_early", 64'(ctrl_done), 64'd0);
      rlast_hs = 1'b1; tick(); rlast_hs = 1'b0;
    end
    check_val("t1_done_lat1", 64'(ctrl_done), 64'd0); tick();
    check_val("t1_done", 64'(ctrl_done), 64'd1);
    check_val("t1_busy_at_done", 64'(ctrl_busy), 64'd1); tick();
    check_val("t1_done_clr", 64'(ctrl_done), 64'd0);
    check_val("t1_busy_clr", 64'(ctrl_busy), 64'd0);

    // 20 full bursts with no retirements: throttled at 16 in flight.
    do_start(64'h0, 32'd1280);
    n_ar = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_axi_arvalid) begin
        check_ar("t2_ar", 64'(n_ar) * STEP, 8'd63);
        n_ar++;
      end
      tick();
    end
    check_val("t2_ar_count", 64'(n_ar), 64'd16);
    check_val("t2_blocked", 64'(m_axi_arvalid), 64'd0);
    rlast_hs = 1'b1; tick(); rlast_hs = 1'b0;
    check_ar("t2_ar17", 64'd16 * STEP, 8'd63); tick();
    check_val("t2_full_again", 64'(m_axi_arvalid), 64'd0); tick();
    check_val("t2_full_again2", 64'(m_axi_arvalid), 64'd0);

    // AR handshake and retirement in the same cycle keep the count unchanged.
    rlast_hs = 1'b1; tick();
    check_ar("t3_ar18", 64'd17 * STEP, 8'd63); tick();
    rlast_hs = 1'b0;
    check_ar("t3_ar19", 64'd18 * STEP, 8'd63); tick();
    for (int c = 0; c < 3; c++) begin
      check_val("t3_blocked", 64'(m_axi_arvalid), 64'd0);
      tick();
    end

    // Stalled AR must hold valid, address and length.
    m_axi_arready = 1'b0;
    rlast_hs = 1'b1; tick(); rlast_hs = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_ar("t4_hold", 64'd19 * STEP, 8'd63);
      tick();
    end
    m_axi_arready = 1'b1;
    check_ar("t4_ar20", 64'd19 * STEP, 8'd63); tick();
    check_val("t4_drain_arvalid", 64'(m_axi_arvalid), 64'd0);
    for (int k = 0; k < 16; k++) begin
      check_val("t4_done_early", 64'(ctrl_done), 64'd0);
      rlast_hs = 1'b1; tick(); rlast_hs = 1'b0;
    end
    check_val("t4_done_lat1", 64'(ctrl_done), 64'd0); tick();
    check_val("t4_done", 64'(ctrl_done), 64'd1); tick();
    check_val("t4_busy_clr", 64'(ctrl_busy), 64'd0);

    // Zero-length transfer: done two cycles after start, no AR.
    do_start(64'h7000, 32'd0);
    check_val("t5_busy", 64'(ctrl_busy), 64'd1);
    check_val("t5_done_lat1", 64'(ctrl_done), 64'd0);
    check_val("t5_no_ar1", 64'(m_axi_arvalid), 64'd0); tick();
    check_val("t5_done", 64'(ctrl_done), 64'd1);
    check_val("t5_no_ar2", 64'(m_axi_arvalid), 64'd0); tick();
    check_val("t5_done_clr", 64'(ctrl_done), 64'd0);
    check_val("t5_busy_clr", 64'(ctrl_busy), 64'd0);

    // Retirement with nothing outstanding raises the sticky error; start clears it.
    rlast_hs = 1'b1; tick(); rlast_hs = 1'b0;
    check_val("uf_set", 64'(err_underflow), 64'd1); tick();
    check_val("uf_sticky", 64'(err_underflow), 64'd1);
    do_start(64'h5000, 32'd0);
    check_val("uf_clr", 64'(err_underflow), 64'd0);
    tick(); tick();

    // Reset in the middle of issuing with 5 bursts outstanding.
    m_axi_arready = 1'b1;
    do_start(64'h40000, 32'd512);
    for (int i = 0; i < 5; i++) begin
      check_ar("t6_ar", 64'h40000 + 64'(i) * STEP, 8'd63);
      tick();
    end
    m_axi_arready = 1'b0;
    areset = 1'b1; tick(); areset = 1'b0;
    check_idle("t6_rst");
    rlast_hs = 1'b1; tick(); rlast_hs = 1'b0;
    check_val("t6_stray_err", 64'(err_underflow), 64'd0);
    m_axi_arready = 1'b1;
    do_start(64'h8000, 32'd1);
    check_ar("t6_len1", 64'h8000, 8'd0);
    ctrl_start = 1'b1; ctrl_addr_offset = 64'hdead000; ctrl_length = 32'd100;
    tick();
    ctrl_start = 1'b0;
    check_val("t6_one_ar", 64'(m_axi_arvalid), 64'd0); tick();
    rlast_hs = 1'b1; tick(); rlast_hs = 1'b0;
    check_val("t6_done_lat1", 64'(ctrl_done), 64'd0); tick();
    check_val("t6_done", 64'(ctrl_done), 64'd1);
    check_val("t6_busy_at_done", 64'(ctrl_busy), 64'd1); tick();
    check_val("t6_busy_clr", 64'(ctrl_busy), 64'd0); tick();
    check_val("t6_ignored_start_ar", 64'(m_axi_arvalid), 64'd0);
    check_val("t6_ignored_start_busy", 64'(ctrl_busy), 64'd0);
    check_val("t6_err", 64'(err_underflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
